// File: rtl/tdm_demultiplexer_if.sv
// Serial-in / four-channel-out bundle for the TDM demultiplexer.
// master drives the sample stream, slave is the demultiplexer.
interface tdm_demultiplexer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0;
  logic [WIDTH-1:0] ch1;
  logic [WIDTH-1:0] ch2;
  logic [WIDTH-1:0] ch3;
  logic [3:0]       ch_valid;
  logic             frame_done;
  logic             sync_err;
  logic             locked;

  modport master (
    output din, din_valid, frame_sync,
    input  ch0, ch1, ch2, ch3,
    input  ch_valid, frame_done,
    input  sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch0, ch1, ch2, ch3,
    output ch_valid, frame_done,
    output sync_err, locked
  );
endinterface

// File: rtl/tdm_demultiplexer.sv
// 1-to-4 TDM demultiplexer locking to frame_sync.
// Define TDM_DEMUX_FRAME_LATCH_EN to publish whole frames at slot 3.
module tdm_demultiplexer #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  tdm_demultiplexer_if.slave bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] ch_q [4];
  logic [3:0]       ch_valid_q;
  logic             frame_done_q;
  logic             sync_err_q;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [WIDTH-1:0] sh_q [3];
`endif

  logic       accept;
  logic       resync;
  logic [1:0] slot_d;
  logic [3:0] slot_oh;

  always_comb begin
    accept  = bus.din_valid &&
              (state_q == LOCKED || bus.frame_sync);
    resync  = bus.din_valid && bus.frame_sync &&
              state_q == LOCKED && slot_q != 2'd0;
    // a sync sample always lands in slot 0
    slot_d  = bus.frame_sync ? 2'd0 : slot_q;
    slot_oh = 4'b0001 << slot_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ch_q[i] <= '0;
      end
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      for (int i = 0; i < 3; i++) begin
        sh_q[i] <= '0;
      end
`endif
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= resync;
      if (accept) begin
        state_q      <= LOCKED;
        slot_q       <= slot_d + 2'd1;
        frame_done_q <= slot_oh[3];
`ifdef TDM_DEMUX_FRAME_LATCH_EN
        unique case (1'b1)
          slot_oh[0]: sh_q[0] <= bus.din;
          slot_oh[1]: sh_q[1] <= bus.din;
          slot_oh[2]: sh_q[2] <= bus.din;
          slot_oh[3]: begin
            ch_q[0]    <= sh_q[0];
            ch_q[1]    <= sh_q[1];
            ch_q[2]    <= sh_q[2];
            ch_q[3]    <= bus.din;
            ch_valid_q <= 4'b1111;
          end
          default: ;
        endcase
`else
        ch_q[slot_d] <= bus.din;
        ch_valid_q   <= slot_oh;
`endif
      end
    end
  end

  assign bus.ch0        = ch_q[0];
  assign bus.ch1        = ch_q[1];
  assign bus.ch2        = ch_q[2];
  assign bus.ch3        = ch_q[3];
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer.
// Stimulus pushes expected output events; a monitor pops them.
module tb_tdm_demultiplexer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tdm_demultiplexer_if #(.WIDTH(8)) bus ();

  tdm_demultiplexer #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
    logic [3:0] v;
    logic       fd;
    logic       se;
    logic       lk;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] d,
    input logic [3:0] v, input logic fd,
    input logic se, input logic lk);
    obs_t o;
    o.c0 = a; o.c1 = b; o.c2 = c; o.c3 = d;
    o.v = v; o.fd = fd; o.se = se; o.lk = lk;
    return o;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.c0 = bus.ch0; o.c1 = bus.ch1;
    o.c2 = bus.ch2; o.c3 = bus.ch3;
    o.v  = bus.ch_valid;
    o.fd = bus.frame_done;
    o.se = bus.sync_err;
    o.lk = bus.locked;
    return o;
  endfunction

  task automatic cmp(input string nm,
                     input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h",
               nm, got, exp);
    end
  endtask

  // monitor: every output event must match the queue head
  always @(negedge clk) begin
    if (bus.ch_valid != 4'd0 || bus.frame_done ||
        bus.sync_err) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_event: got %h required none",
                 cur());
      end else begin
        cmp("event", cur(), expq.pop_front());
      end
    end
  end

  task automatic ev(input obs_t e);
    expq.push_back(e);
  endtask

  task automatic smp(input logic [7:0] d, input logic s);
    @(negedge clk);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din        = 8'hEE;
      bus.din_valid  = 1'b0;
      bus.frame_sync = 1'b1;
    end
  endtask

  task automatic idle_chk(input string nm, input obs_t e);
    @(negedge clk);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    @(posedge clk);
    #1;
    cmp(nm, cur(), e);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    @(posedge clk);
    #1;
    cmp(nm, cur(), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.din        = 8'h00;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;

    // back-to-back frame, then wrap into slot 0
    do_reset("reset0");
    smp(8'hA0, 1'b1);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 1));
`endif
    smp(8'hA1, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'h00, 8'h00, 4'h2, 0, 0, 1));
`endif
    smp(8'hA2, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'h00, 4'h4, 0, 0, 1));
`endif
    smp(8'hA3, 1'b0);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1, 0, 1));
`else
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h8, 1, 0, 1));
`endif
    idle_chk("hold",
             mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h0, 0, 0, 1));
    smp(8'hB0, 1'b0);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    idle_chk("wrap",
             mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h0, 0, 0, 1));
`else
    ev(mk(8'hB0, 8'hA1, 8'hA2, 8'hA3, 4'h1, 0, 0, 1));
    idle_chk("wrap",
             mk(8'hB0, 8'hA1, 8'hA2, 8'hA3, 4'h0, 0, 0, 1));
`endif

    // samples before sync are dropped
    do_reset("reset1");
    smp(8'h11, 1'b0);
    smp(8'h22, 1'b0);
    idle_chk("prelock", '0);
    smp(8'h33, 1'b1);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h33, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 1));
`endif

    // sync arriving at slot 2 realigns
    smp(8'h44, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h33, 8'h44, 8'h00, 8'h00, 4'h2, 0, 0, 1));
`endif
    smp(8'h55, 1'b1);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 1));
`else
    ev(mk(8'h55, 8'h44, 8'h00, 8'h00, 4'h1, 0, 1, 1));
`endif
    smp(8'h66, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h55, 8'h66, 8'h00, 8'h00, 4'h2, 0, 0, 1));
`endif
    smp(8'h77, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h55, 8'h66, 8'h77, 8'h00, 4'h4, 0, 0, 1));
`endif
    smp(8'h88, 1'b0);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'h55, 8'h66, 8'h77, 8'h88, 4'hF, 1, 0, 1));
`else
    ev(mk(8'h55, 8'h66, 8'h77, 8'h88, 4'h8, 1, 0, 1));
`endif

    // gapped stream with unqualified frame_sync in the gaps
    do_reset("reset2");
    smp(8'hA0, 1'b1);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 1));
`endif
    gap(3);
    smp(8'hA1, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'h00, 8'h00, 4'h2, 0, 0, 1));
`endif
    gap(3);
    smp(8'hA2, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'h00, 4'h4, 0, 0, 1));
`endif
    gap(3);
    smp(8'hA3, 1'b0);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'hF, 1, 0, 1));
`else
    ev(mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h8, 1, 0, 1));
`endif
    gap(3);
    idle_chk("gaphold",
             mk(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'h0, 0, 0, 1));

    // reset mid-frame, then a non-sync sample is ignored
    do_reset("reset3");
    smp(8'hA0, 1'b1);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'h00, 8'h00, 8'h00, 4'h1, 0, 0, 1));
`endif
    smp(8'hA1, 1'b0);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    ev(mk(8'hA0, 8'hA1, 8'h00, 8'h00, 4'h2, 0, 0, 1));
`endif
    do_reset("midreset");
    smp(8'h99, 1'b0);
    idle_chk("ignored", '0);

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0",
               expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
